// File: rtl/mmio_clint_hub.sv
// mmio_clint_hub: MMIO responder that owns a multi-hart CLINT (per-hart msip
// and mtimecmp, shared prescaled mtime) plus a free-running RTC counter.
// Accesses are launched by a start pulse and answered with req/rdata/err,
// which are held until the consumer acks.
module mmio_clint_hub #(
  parameter int unsigned NUM_HARTS  = 1,
  parameter int unsigned TIMER_DIV  = 1,
  parameter logic [63:0] CLINT_BASE = 64'h0000_0000_0200_0000,
  parameter logic [63:0] RTC_ADDR   = 64'h0000_0000_0200_BFF0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ack,
  input  logic                 ren,
  input  logic                 wen,
  input  logic [63:0]          addr,
  input  logic [63:0]          wdata,
  input  logic [7:0]           wstrb,
  output logic                 req,
  output logic [63:0]          rdata,
  output logic                 err,
  output logic [NUM_HARTS-1:0] o_mtip,
  output logic [NUM_HARTS-1:0] o_msip
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  typedef enum logic {IDLE, RESP} state_e;

  state_e                     state_q, state_d;
  logic [63:0]                rdata_q, rdata_d;
  logic                       err_q, err_d;
  logic [NUM_HARTS-1:0]       msip_q, msip_d;
  logic [NUM_HARTS-1:0][63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0]                mtime_q, mtime_d;
  logic [PW-1:0]              presc_q, presc_d;
  logic [63:0]                rtc_q;
  logic [NUM_HARTS-1:0]       mtip_q, mtip_d;
  logic [NUM_HARTS-1:0]       msipIrq_q;

  logic [63:0] offset;
  logic        hitMsip, hitCmp, hitMtime, hitRtc;
  logic [2:0]  hartSel;
  logic        lane, laneStrb, laneBit;
  logic        mtimeWr;
  logic [63:0] mtimeWrData;

  function automatic logic [63:0] mergeBytes(input logic [63:0] old,
                                             input logic [63:0] data,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode: which register (if any) the access targets, and its hart.
  always_comb begin
    offset   = addr - CLINT_BASE;
    hitRtc   = (addr == RTC_ADDR);
    hitMtime = !hitRtc && (offset == 64'hBFF8);
    hitMsip  = !hitRtc && (offset < 64'(4 * NUM_HARTS)) && (offset[1:0] == 2'b00);
    hitCmp   = !hitRtc && (offset >= 64'h4000) &&
               (offset < 64'h4000 + 64'(8 * NUM_HARTS)) && (offset[2:0] == 3'b000);
    hartSel  = hitCmp ? offset[5:3] : offset[4:2];
    lane     = addr[2];
    laneStrb = lane ? wstrb[4] : wstrb[0];
    laneBit  = lane ? wdata[32] : wdata[0];
  end

  // Handshake FSM and access execution: reads and writes take effect in the
  // IDLE cycle that sees start; RESP just holds the response until ack.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    mtimeWr     = 1'b0;
    mtimeWrData = mtime_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b0;
          if (ren || wen) begin
            if (!(hitRtc || hitMtime || hitMsip || hitCmp)) begin
              err_d = 1'b1;
            end else if (ren) begin
              if (hitRtc) rdata_d = rtc_q;
              else if (hitMtime) rdata_d = mtime_q;
              else begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                  if (hartSel == 3'(h)) begin
                    if (hitMsip) rdata_d = lane ? {31'b0, msip_q[h], 32'b0} : {63'b0, msip_q[h]};
                    else rdata_d = mtimecmp_q[h];
                  end
                end
              end
            end else begin
              if (hitMtime && (wstrb != 8'h00)) begin
                mtimeWr     = 1'b1;
                mtimeWrData = mergeBytes(mtime_q, wdata, wstrb);
              end
              for (int h = 0; h < NUM_HARTS; h++) begin
                if (hartSel == 3'(h)) begin
                  if (hitMsip && laneStrb) msip_d[h] = laneBit;
                  if (hitCmp) mtimecmp_d[h] = mergeBytes(mtimecmp_q[h], wdata, wstrb);
                end
              end
            end
          end
        end
      end
      RESP: begin
        if (ack) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaled mtime; a bus write overrides the tick and restarts the prescaler.
  always_comb begin
    mtime_d = mtime_q;
    presc_d = presc_q;
    if (mtimeWr) begin
      mtime_d = mtimeWrData;
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      mtime_d = mtime_q + 64'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Per-hart timer compare against the current register values.
  always_comb begin
    mtip_d = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  // State registers; interrupt lines lag their sources by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      msip_q     <= '0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
      presc_q    <= '0;
      rtc_q      <= '0;
      mtip_q     <= '0;
      msipIrq_q  <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
      rtc_q      <= rtc_q + 64'd1;
      mtip_q     <= mtip_d;
      msipIrq_q  <= msip_q;
    end
  end

  assign req    = (state_q == RESP);
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign o_mtip = mtip_q;
  assign o_msip = msipIrq_q;

endmodule

// File: tb/tb_mmio_clint_hub.sv
// tb_mmio_clint_hub: directed bench for mmio_clint_hub with a cycle-level
// reference model of the register map, timer and handshake.
module tb_mmio_clint_hub;

  localparam int NH  = 2;
  localparam int DIV = 4;
  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] RTC  = 64'h0000_0000_0200_BFF0;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int K_ERR = 0, K_MSIP = 1, K_CMP = 2, K_MTIME = 3, K_RTC = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ack = 1'b0, ren = 1'b0, wen = 1'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        req, err;
  logic [63:0] rdata;
  logic [NH-1:0] o_mtip, o_msip;

  int vectors = 0, miscompares = 0;
  longint unsigned tbCycle = 0;

  logic [63:0]     anchorVal, cmpM [NH];
  longint unsigned edgeM, anchorEdge, rstEdge;
  logic [NH-1:0]   msipM, expMtip, expMsip;
  logic            busy, expReq, expErr, modelValid = 1'b0;
  logic [63:0]     expRdata;
  logic [63:0]     errAddr [4];

  mmio_clint_hub #(
    .NUM_HARTS(NH), .TIMER_DIV(DIV), .CLINT_BASE(BASE), .RTC_ADDR(RTC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack), .ren(ren), .wen(wen),
    .addr(addr), .wdata(wdata), .wstrb(wstrb), .req(req), .rdata(rdata),
    .err(err), .o_mtip(o_mtip), .o_msip(o_msip)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to time interrupt edges.
  always @(posedge clk) tbCycle <= tbCycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] mask;
    for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{s[b]}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic void decode(input logic [63:0] a, output int kind, output int hart);
    kind = K_ERR;
    hart = 0;
    if (a == RTC) kind = K_RTC;
    else if (a == BASE + 64'hBFF8) kind = K_MTIME;
    else begin
      for (int h = 0; h < NH; h++) begin
        if (a == BASE + 64'(4 * h)) begin kind = K_MSIP; hart = h; end
        if (a == BASE + 64'h4000 + 64'(8 * h)) begin kind = K_CMP; hart = h; end
      end
    end
  endfunction

  // Reference model: mtime is derived from the cycles elapsed since its last
  // anchor (reset or bus write), rtc from cycles since reset.
  initial begin
    logic [63:0] curMtime, curRtc;
    int kind, hart, lane;
    edgeM = 0;
    forever begin
      @(posedge clk);
      edgeM++;
      if (rst) begin
        anchorVal = '0; anchorEdge = edgeM; rstEdge = edgeM;
        msipM = '0;
        for (int h = 0; h < NH; h++) cmpM[h] = ONES;
        busy = 1'b0; expReq = 1'b0; expErr = 1'b0; expRdata = '0;
        expMtip = '0; expMsip = '0;
        modelValid = 1'b1;
      end else begin
        curMtime = anchorVal + (edgeM - 1 - anchorEdge) / 64'(DIV);
        curRtc   = edgeM - 1 - rstEdge;
        for (int h = 0; h < NH; h++) expMtip[h] = (curMtime >= cmpM[h]);
        expMsip = msipM;
        if (!busy) begin
          if (start) begin
            busy = 1'b1; expReq = 1'b1; expRdata = '0; expErr = 1'b0;
            if (ren || wen) begin
              decode(addr, kind, hart);
              lane = hart % 2;
              if (kind == K_ERR) expErr = 1'b1;
              else if (ren) begin
                case (kind)
                  K_MSIP:  expRdata = (lane == 1) ? {31'b0, msipM[hart], 32'b0} : {63'b0, msipM[hart]};
                  K_CMP:   expRdata = cmpM[hart];
                  K_MTIME: expRdata = curMtime;
                  default: expRdata = curRtc;
                endcase
              end else begin
                case (kind)
                  K_MSIP:  if (wstrb[4*lane]) msipM[hart] = wdata[32*lane];
                  K_CMP:   cmpM[hart] = merge(cmpM[hart], wdata, wstrb);
                  K_MTIME: if (wstrb != 8'h00) begin
                             anchorVal = merge(curMtime, wdata, wstrb);
                             anchorEdge = edgeM;
                           end
                  default: ;
                endcase
              end
            end
          end
        end else if (ack) begin
          busy = 1'b0; expReq = 1'b0; expRdata = '0; expErr = 1'b0;
        end
      end
    end
  end

  // Compare DUT outputs with the model every cycle, away from the clock edge.
  initial forever begin
    @(negedge clk);
    if (modelValid) begin
      checkOutput("req", {63'b0, req}, {63'b0, expReq});
      checkOutput("rdata", rdata, expRdata);
      checkOutput("err", {63'b0, err}, {63'b0, expErr});
      checkOutput("o_mtip", 64'(o_mtip), 64'(expMtip));
      checkOutput("o_msip", 64'(o_msip), 64'(expMsip));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [63:0] a,
                               input logic [63:0] d, input logic [7:0] s);
    start = 1'b1; ren = r; wen = w; addr = a; wdata = d; wstrb = s;
    tick(1);
    start = 1'b0; ren = 1'b0; wen = 1'b0;
  endtask

  task automatic waitResponse(output logic [63:0] rd, output logic e);
    int lat;
    lat = 1;
    while (req !== 1'b1 && lat < 20) begin tick(1); lat++; end
    checkOutput("latency", 64'(lat), 64'd1);
    rd = rdata; e = err;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic doAccess(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, output logic [63:0] rd, output logic e);
    applyStimulus(r, w, a, d, s);
    waitResponse(rd, e);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [63:0] rd;
    logic e;
    longint unsigned execEdge;

    tick(3);
    rst = 1'b0;
    tick(10);
    checkOutput("idle_req", {63'b0, req}, 64'd0);
    checkOutput("idle_mtip", 64'(o_mtip), 64'd0);
    checkOutput("idle_msip", 64'(o_msip), 64'd0);

    doAccess(1, 0, BASE + 64'h4000, '0, 8'h00, rd, e);
    checkOutput("cmp0_reset_rdata", rd, ONES);
    checkOutput("cmp0_reset_err", {63'b0, e}, 64'd0);

    // Timer: cmp=8, then mtime=0 -> mtip rises 33 cycles after the write.
    doAccess(0, 1, BASE + 64'h4000, 64'd8, 8'hFF, rd, e);
    applyStimulus(0, 1, BASE + 64'hBFF8, 64'd0, 8'hFF);
    execEdge = tbCycle;
    waitResponse(rd, e);
    while (o_mtip[0] !== 1'b1 && tbCycle < execEdge + 100) tick(1);
    checkOutput("mtip_rise_delay", tbCycle - execEdge, 64'd33);
    applyStimulus(0, 1, BASE + 64'h4000, 64'd100, 8'hFF);
    tick(1);
    checkOutput("mtip_fall", 64'(o_mtip[0]), 64'd0);
    waitResponse(rd, e);
    doAccess(1, 0, BASE + 64'hBFF8, '0, 8'h00, rd, e);
    doAccess(1, 0, RTC, '0, 8'h00, rd, e);
    doAccess(0, 1, RTC, 64'd5, 8'hFF, rd, e);
    checkOutput("rtc_write_err", {63'b0, e}, 64'd0);

    // Software interrupt for hart 1 via the upper lane.
    doAccess(0, 1, BASE + 64'h4, 64'h0000_0001_0000_0000, 8'hF0, rd, e);
    checkOutput("msip_out", 64'(o_msip), 64'd2);
    doAccess(1, 0, BASE + 64'h4, '0, 8'h00, rd, e);
    checkOutput("msip1_read", rd, 64'h0000_0001_0000_0000);

    // Partial byte write.
    doAccess(0, 1, BASE + 64'h4008, 64'h1122_3344_5566_7788, 8'hFF, rd, e);
    doAccess(0, 1, BASE + 64'h4008, 64'h0000_0000_0000_00AA, 8'h01, rd, e);
    doAccess(1, 0, BASE + 64'h4008, '0, 8'h00, rd, e);
    checkOutput("cmp1_partial", rd, 64'h1122_3344_5566_77AA);

    // Error paths leave the registers untouched.
    errAddr[0] = BASE + 64'h4004;
    errAddr[1] = BASE + 64'h4010;
    errAddr[2] = 64'h5000_0000;
    errAddr[3] = BASE + 64'h8;
    for (int i = 0; i < 4; i++) begin
      doAccess(i != 2, i == 2, errAddr[i], 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, rd, e);
      checkOutput("err_flag", {63'b0, e}, 64'd1);
      checkOutput("err_rdata", rd, 64'd0);
    end
    doAccess(1, 0, BASE + 64'h4008, '0, 8'h00, rd, e);
    checkOutput("cmp1_after_err", rd, 64'h1122_3344_5566_77AA);
    doAccess(1, 0, BASE + 64'h4000, '0, 8'h00, rd, e);
    checkOutput("cmp0_after_err", rd, 64'd100);

    // Neither ren nor wen: plain response, no error.
    doAccess(0, 0, 64'h5000_0000, '0, 8'hFF, rd, e);
    checkOutput("noop_err", {63'b0, e}, 64'd0);

    // Held response, and a start during RESP that must be ignored.
    applyStimulus(1, 0, BASE + 64'h4008, '0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("hold_req", {63'b0, req}, 64'd1);
      checkOutput("hold_rdata", rdata, 64'h1122_3344_5566_77AA);
    end
    start = 1'b1; wen = 1'b1; addr = BASE + 64'h4008; wdata = '0; wstrb = 8'hFF;
    tick(1);
    start = 1'b0; wen = 1'b0;
    checkOutput("resp_start_rdata", rdata, 64'h1122_3344_5566_77AA);
    waitResponse(rd, e);
    doAccess(1, 0, BASE + 64'h4008, '0, 8'h00, rd, e);
    checkOutput("cmp1_after_ignored", rd, 64'h1122_3344_5566_77AA);

    // Ack coinciding with start in IDLE is not taken as the response ack.
    ack = 1'b1;
    applyStimulus(1, 0, BASE + 64'hBFF8, '0, 8'h00);
    ack = 1'b0;
    tick(1);
    checkOutput("start_ack_req", {63'b0, req}, 64'd1);
    waitResponse(rd, e);

    // Reset while a write response is pending.
    applyStimulus(0, 1, BASE + 64'h4000, 64'h1234, 8'hFF);
    rst = 1'b1;
    tick(1);
    checkOutput("rst_resp_req", {63'b0, req}, 64'd0);
    rst = 1'b0;
    doAccess(1, 0, BASE + 64'h4000, '0, 8'h00, rd, e);
    checkOutput("cmp0_after_rst", rd, ONES);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
